// File: rtl/rr_chan_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
// The optional hold limit is enabled with RR_CHAN_ARBITER_HOLD_LIMIT_EN.
package rr_chan_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRelease
  } state_e;

  // OR-tree encoder: index bit b is the OR of every one-hot bit whose position has bit b set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned b = 0; b < IDX_W; b++) begin
        if (((i >> b) & 32'd1) != 32'd0) begin
          idx[b] = idx[b] | oh[i];
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at ptr, ptr+1, ... (mod N_REQ).
// Works by rotating so ptr lands at bit 0, isolating the lowest set bit, then rotating back.
module rr_pick
  import rr_chan_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [2*N_REQ-1:0] oh_dbl;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_oh;

  always_comb begin
    req_dbl  = {req_i, req_i};
    rot_dbl  = req_dbl >> ptr_i;
    rot_req  = rot_dbl[N_REQ-1:0];
    // Two's-complement trick keeps only the lowest set bit.
    rot_oh   = rot_req & (~rot_req + {{(N_REQ-1){1'b0}}, 1'b1});
    oh_dbl   = {rot_oh, rot_oh} << ptr_i;
    onehot_o = oh_dbl[2*N_REQ-1:N_REQ];
    found_o  = |req_i;
    idx_o    = onehot_to_idx(onehot_o);
  end

endmodule

// File: rtl/rr_chan_arbiter.sv
// Round-robin arbiter sharing one serial channel among N_REQ requesters.
// Define RR_CHAN_ARBITER_HOLD_LIMIT_EN to force release after HoldMax cycles in BUSY.
module rr_chan_arbiter
  import rr_chan_pkg::*;
#(
  parameter int unsigned HoldMax = 16,
  parameter int unsigned IdleGap = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] tx_bit_i,
  input  logic             rx_bit_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] sel_o,
  output logic             chan_valid_o,
  output logic             chan_bit_o,
  output logic [N_REQ-1:0] rx_out_o,
  output logic [4:0]       hold_cnt_o
);

  if (HoldMax < 2 || HoldMax > 32) begin : g_bad_hold_max
    $error("HoldMax must be in 2..32");
  end
  if (IdleGap < 1 || IdleGap > 3) begin : g_bad_idle_gap
    $error("IdleGap must be in 1..3");
  end

  localparam logic [1:0] GapLast = 2'(IdleGap - 1);
  localparam logic [4:0] HoldSat = 5'd31;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [4:0]       hold_q, hold_d;
  logic [1:0]       gap_q, gap_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             preempt;

  rr_pick u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

`ifdef RR_CHAN_ARBITER_HOLD_LIMIT_EN
  localparam logic [4:0] HoldLast = 5'(HoldMax - 1);
  assign preempt = (hold_q == HoldLast);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_oh;
          sel_d   = pick_idx;
          hold_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        hold_d = (hold_q == HoldSat) ? hold_q : hold_q + 5'd1;
        if (!req_i[sel_q] || preempt) begin
          gnt_d   = '0;
          // Advancing past the owner puts it last in line for the next arbitration.
          ptr_d   = sel_q + IDX_W'(1);
          gap_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (gap_q == GapLast) begin
          hold_d  = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    gnt_o        = gnt_q;
    sel_o        = sel_q;
    hold_cnt_o   = hold_q;
    chan_valid_o = (state_q == StBusy);
    chan_bit_o   = chan_valid_o & tx_bit_i[sel_q];
    rx_out_o     = chan_valid_o ? ({{(N_REQ-1){1'b0}}, rx_bit_i} << sel_q) : '0;
  end

endmodule

// File: tb/tb_rr_chan_arbiter.sv
// Self-checking bench for rr_chan_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_rr_chan_arbiter;

  localparam int unsigned HOLD_MAX = 16;
  localparam int unsigned IDLE_GAP = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] tx;
  logic       rx;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       chan_valid;
  logic       chan_bit;
  logic [7:0] rx_out;
  logic [4:0] hold_cnt;

  int unsigned n_chk;
  int unsigned n_pass;

  rr_chan_arbiter #(
    .HoldMax (HOLD_MAX),
    .IdleGap (IDLE_GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .tx_bit_i     (tx),
    .rx_bit_i     (rx),
    .gnt_o        (gnt),
    .sel_o        (sel),
    .chan_valid_o (chan_valid),
    .chan_bit_o   (chan_bit),
    .rx_out_o     (rx_out),
    .hold_cnt_o   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tx    = '0;
    rx    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [7:0] req;
    logic [7:0] tx;
    logic       rx;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       cb;
    logic [7:0] rxo;
  } vec_t;

  vec_t vecs[6];

  // Reference model state: owner of the channel (-1 when free), dead cycles left, pointer.
  int m_owner, m_cool, m_ptr, m_hold, m_sel;

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit leave;
    bit found;
    int idx;
    if (m_owner >= 0) begin
      leave = !r[m_owner];
`ifdef RR_CHAN_ARBITER_HOLD_LIMIT_EN
      if (m_hold == int'(HOLD_MAX) - 1) leave = 1'b1;
`endif
      if (m_hold < 31) m_hold++;
      if (leave) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = IDLE_GAP;
      end
    end else if (m_cool > 0) begin
      m_cool--;
      if (m_cool == 0) m_hold = 0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (!found && r[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_sel   = idx;
          m_hold  = 0;
        end
      end
    end
  endtask

  initial begin
    int   g_idx;
    int   zeros;
    bit   got;
    logic [7:0]  e_gnt;
    logic [7:0]  e_rxo;
    logic        e_cb;
    logic [7:0]  rx_exp[3];
    logic        rx_pat[3];
    logic [25:0] act_v;
    logic [25:0] exp_v;

    n_chk  = 0;
    n_pass = 0;

    vecs[0] = '{req: 8'h04, tx: 8'h04, rx: 1'b1, gnt: 8'h04, sel: 3'd2, cb: 1'b1, rxo: 8'h04};
    vecs[1] = '{req: 8'hA0, tx: 8'h5F, rx: 1'b0, gnt: 8'h20, sel: 3'd5, cb: 1'b0, rxo: 8'h00};
    vecs[2] = '{req: 8'h80, tx: 8'h80, rx: 1'b1, gnt: 8'h80, sel: 3'd7, cb: 1'b1, rxo: 8'h80};
    vecs[3] = '{req: 8'h01, tx: 8'h00, rx: 1'b1, gnt: 8'h01, sel: 3'd0, cb: 1'b0, rxo: 8'h01};
    vecs[4] = '{req: 8'hFE, tx: 8'h02, rx: 1'b1, gnt: 8'h02, sel: 3'd1, cb: 1'b1, rxo: 8'h02};
    vecs[5] = '{req: 8'h18, tx: 8'hFF, rx: 1'b0, gnt: 8'h08, sel: 3'd3, cb: 1'b1, rxo: 8'h00};

    // Reset state, with live data inputs that must not leak through.
    do_reset();
    tx = 8'hFF;
    rx = 1'b1;
    #1;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset sel", 32'(sel), 32'h0);
    chk("reset chan_valid", 32'(chan_valid), 32'h0);
    chk("reset chan_bit", 32'(chan_bit), 32'h0);
    chk("reset rx_out", 32'(rx_out), 32'h0);
    chk("reset hold_cnt", 32'(hold_cnt), 32'h0);

    // Vector table: first grant after reset (ptr=0).
    for (int v = 0; v < 6; v++) begin
      do_reset();
      req = vecs[v].req;
      tx  = vecs[v].tx;
      rx  = vecs[v].rx;
      cyc();
      chk($sformatf("vec%0d gnt", v), 32'(gnt), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d sel", v), 32'(sel), 32'(vecs[v].sel));
      chk($sformatf("vec%0d chan_bit", v), 32'(chan_bit), 32'(vecs[v].cb));
      chk($sformatf("vec%0d rx_out", v), 32'(rx_out), 32'(vecs[v].rxo));
      req = '0;
      cyc();
    end

    // Single grant, live chan_bit, release, then ptr=3 decides between 2 and 3.
    do_reset();
    req = 8'h04;
    tx  = 8'h04;
    cyc();
    chk("seq1 gnt", 32'(gnt), 32'h04);
    chk("seq1 sel", 32'(sel), 32'd2);
    chk("seq1 chan_bit hi", 32'(chan_bit), 32'd1);
    tx = 8'hFB;
    #1;
    chk("seq1 chan_bit lo", 32'(chan_bit), 32'd0);
    cyc();
    chk("seq1 hold_cnt", 32'(hold_cnt), 32'd1);
    req = '0;
    cyc();
    chk("seq1 release gnt", 32'(gnt), 32'h0);
    chk("seq1 release valid", 32'(chan_valid), 32'h0);
    cyc();
    req = 8'h0C;
    cyc();
    chk("seq1 ptr3 sel", 32'(sel), 32'd3);
    req = '0;
    repeat (3) cyc();

    // All requesting: rotation 0..7,0 with IDLE_GAP+1 empty cycles between grants.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      zeros = 0;
      got   = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        if (gnt != 8'h00) got = 1'b1;
        else begin
          zeros++;
          cyc();
        end
      end
      if (!got) begin
        n_chk++;
        $display("FAIL rotation grant %0d: no grant within 20 cycles, expected index %0d", g, g % 8);
      end else begin
        chk($sformatf("rotation %0d index", g), 32'(oh_idx(gnt)), 32'(g % 8));
        chk($sformatf("rotation %0d onehot", g), 32'($countones(gnt)), 32'd1);
        if (g > 0) chk($sformatf("rotation %0d gap", g), 32'(zeros), 32'(IDLE_GAP + 1));
        g_idx = oh_idx(gnt);
        repeat (2) cyc();
        req[g_idx] = 1'b0;
        cyc();
        req[g_idx] = 1'b1;
      end
    end
    req = '0;
    repeat (4) cyc();

    // Wrap-around: ptr=6 with requests at 6 and 0.
    do_reset();
    req = 8'h20;
    cyc();
    req = '0;
    repeat (2) cyc();
    req = 8'h41;
    cyc();
    chk("wrap first gnt", 32'(gnt), 32'h40);
    req = 8'h01;
    repeat (3) cyc();
    chk("wrap second gnt", 32'(gnt), 32'h01);
    req = '0;
    repeat (3) cyc();

    // Return path routed to requester 5 only.
    do_reset();
    req = 8'h20;
    cyc();
    rx_pat = '{1'b1, 1'b0, 1'b1};
    rx_exp = '{8'h20, 8'h00, 8'h20};
    for (int i = 0; i < 3; i++) begin
      rx = rx_pat[i];
      #1;
      chk($sformatf("rx_out step %0d", i), 32'(rx_out), 32'(rx_exp[i]));
      cyc();
    end

    // Asynchronous reset mid-transfer, then arbitration restarts from ptr=0.
    do_reset();
    req = 8'h20;
    cyc();
    req = '0;
    repeat (2) cyc();
    req = 8'h08;
    tx  = 8'hFF;
    rx  = 1'b1;
    cyc();
    chk("pre-reset sel", 32'(sel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset gnt", 32'(gnt), 32'h0);
    chk("async reset sel", 32'(sel), 32'h0);
    chk("async reset valid", 32'(chan_valid), 32'h0);
    chk("async reset chan_bit", 32'(chan_bit), 32'h0);
    chk("async reset rx_out", 32'(rx_out), 32'h0);
    chk("async reset hold_cnt", 32'(hold_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h88;
    cyc();
    chk("post-reset gnt", 32'(gnt), 32'h08);

    // Long hold by requester 0 with requester 1 waiting.
    do_reset();
    req = 8'h03;
    cyc();
`ifdef RR_CHAN_ARBITER_HOLD_LIMIT_EN
    for (int i = 0; i < int'(HOLD_MAX); i++) begin
      chk($sformatf("hold cycle %0d gnt", i), 32'(gnt), 32'h01);
      cyc();
    end
    chk("preempt release gnt", 32'(gnt), 32'h0);
    repeat (2) cyc();
    chk("preempt next gnt", 32'(gnt), 32'h02);
`else
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) chk($sformatf("hold cycle %0d gnt", i), 32'(gnt), 32'h01);
      cyc();
    end
    chk("hold kept gnt", 32'(gnt), 32'h01);
    chk("hold_cnt saturated", 32'(hold_cnt), 32'd31);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      req = req ^ 8'($urandom() & $urandom() & $urandom());
      tx  = 8'($urandom());
      rx  = 1'($urandom());
      #3;
      e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      e_cb  = (m_owner >= 0) ? tx[m_owner] : 1'b0;
      e_rxo = (m_owner >= 0) ? 8'({7'd0, rx} << m_owner) : 8'h00;
      act_v = {gnt, sel, chan_valid, chan_bit, rx_out, hold_cnt};
      exp_v = {e_gnt, 3'(m_sel), (m_owner >= 0), e_cb, e_rxo, 5'(m_hold)};
      chk($sformatf("random cycle %0d {gnt,sel,valid,bit,rx_out,hold}", c), 32'(act_v),
          32'(exp_v));
      @(posedge clk);
      model_step(req);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
